// File: rtl/xor_fold_stream_if.sv
// Stream bundle for xor_fold_stream: input beats, flush, folded output and the fold counter.
// O_parity exists only when XOR_FOLD_STREAM_PARITY_EN is defined.
interface xor_fold_stream_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 8
);
  localparam int unsigned CntW = $clog2(COUNT);

  logic [WIDTH-1:0] I;
  logic             I_valid;
  logic             I_ready;
  logic             FLUSH;
  logic [WIDTH-1:0] O;
  logic             O_valid;
  logic             O_ready;
  logic [CntW-1:0]  CNT;
`ifdef XOR_FOLD_STREAM_PARITY_EN
  logic             O_parity;
`endif

  // Source/sink side
  modport master (
`ifdef XOR_FOLD_STREAM_PARITY_EN
    input  O_parity,
`endif
    output I, I_valid, FLUSH, O_ready,
    input  I_ready, O, O_valid, CNT
  );

  // Folding block side
  modport slave (
`ifdef XOR_FOLD_STREAM_PARITY_EN
    output O_parity,
`endif
    input  I, I_valid, FLUSH, O_ready,
    output I_ready, O, O_valid, CNT
  );
endinterface

// File: rtl/xor_fold_stream.sv
// XOR-folds every COUNT accepted words into one registered result with a one-deep output stage.
// Define XOR_FOLD_STREAM_PARITY_EN to add a registered O_parity alongside O.
module xor_fold_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 8
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  xor_fold_stream_if.slave   bus
);
  localparam int unsigned CntW = $clog2(COUNT);
  localparam logic [CntW-1:0] CntLast = CntW'(COUNT - 1);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] o_q;
  logic             o_valid_q;

  logic             last_beat;
  logic             i_ready;
  logic             accept;
  logic [WIDTH-1:0] fold_d;

  always_comb begin
    last_beat = (state_q == StAccum) && (cnt_q == CntLast);
    // Stall only when the final beat would overwrite a result the sink has not taken
    i_ready   = !bus.FLUSH && !(last_beat && o_valid_q && !bus.O_ready);
    accept    = bus.I_valid && i_ready;
    fold_d    = acc_q ^ bus.I;
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      if (bus.FLUSH) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        acc_q   <= '0;
      end else if (accept) begin
        unique case (state_q)
          StIdle: begin
            acc_q   <= bus.I;
            cnt_q   <= CntW'(1);
            state_q <= StAccum;
          end
          StAccum: begin
            if (cnt_q == CntLast) begin
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= StIdle;
            end else begin
              acc_q <= fold_d;
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end

      if (accept && last_beat) begin
        o_q       <= fold_d;
        o_valid_q <= 1'b1;
      end else if (bus.O_ready) begin
        o_valid_q <= 1'b0;
      end
    end
  end

`ifdef XOR_FOLD_STREAM_PARITY_EN
  logic o_parity_q;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      o_parity_q <= 1'b0;
    end else if (accept && last_beat) begin
      o_parity_q <= ^fold_d;
    end
  end

  assign bus.O_parity = o_parity_q;
`endif

  assign bus.I_ready = i_ready;
  assign bus.O       = o_q;
  assign bus.O_valid = o_valid_q;
  assign bus.CNT     = cnt_q;
endmodule

// File: tb/tb_xor_fold_stream.sv
// Directed bench for xor_fold_stream (WIDTH=8, COUNT=8) with hand-computed fold results.
module tb_xor_fold_stream;
  logic clk;
  logic rstn;
  int   total;
  int   passed;
  logic irdy_low;

  xor_fold_stream_if #(.WIDTH(8), .COUNT(8)) bus ();

  xor_fold_stream #(.WIDTH(8), .COUNT(8)) dut (
    .CLK         (clk),
    .ASYNCRESETN (rstn),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply inputs and let I_ready settle
  task automatic drive(input logic [7:0] d, input logic v, input logic f, input logic r);
    bus.I       = d;
    bus.I_valid = v;
    bus.FLUSH   = f;
    bus.O_ready = r;
    #1;
    if (v && !bus.I_ready) irdy_low = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic v, input logic f, input logic r);
    drive(d, v, f, r);
    step();
  endtask

  initial begin
    logic [7:0] seq [8];
    logic [7:0] hi  [8];
    logic [7:0] rv  [8];
    total    = 0;
    passed   = 0;
    irdy_low = 1'b0;
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    hi  = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08};
    rv  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h03};

    // Reset values, checked before any clock edge
    rstn        = 1'b0;
    bus.I       = '0;
    bus.I_valid = 1'b0;
    bus.FLUSH   = 1'b0;
    bus.O_ready = 1'b0;
    #1;
    chk("rst_cnt", 32'(bus.CNT), 0);
    chk("rst_ovalid", 32'(bus.O_valid), 0);
    chk("rst_o", 32'(bus.O), 0);
    chk("rst_iready", 32'(bus.I_ready), 1);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Basic fold: 0x01..0x08 -> 0x08
    for (int i = 0; i < 7; i++) beat(seq[i], 1'b1, 1'b0, 1'b1);
    chk("basic_cnt7", 32'(bus.CNT), 7);
    chk("basic_ovalid_early", 32'(bus.O_valid), 0);
    beat(seq[7], 1'b1, 1'b0, 1'b1);
    chk("basic_o", 32'(bus.O), 32'h08);
    chk("basic_ovalid", 32'(bus.O_valid), 1);
    chk("basic_cnt0", 32'(bus.CNT), 0);
`ifdef XOR_FOLD_STREAM_PARITY_EN
    chk("basic_parity", 32'(bus.O_parity), 1);
`endif
    beat(8'h00, 1'b0, 1'b0, 1'b1);
    chk("basic_drained", 32'(bus.O_valid), 0);

    // Back-to-back: 16 x 0xFF -> two 0x00 results, no stall
    irdy_low = 1'b0;
    for (int i = 0; i < 8; i++) beat(8'hFF, 1'b1, 1'b0, 1'b1);
    chk("b2b_first_valid", 32'(bus.O_valid), 1);
    chk("b2b_first_o", 32'(bus.O), 0);
    for (int i = 0; i < 8; i++) beat(8'hFF, 1'b1, 1'b0, 1'b1);
    chk("b2b_second_valid", 32'(bus.O_valid), 1);
    chk("b2b_second_o", 32'(bus.O), 0);
    chk("b2b_cnt", 32'(bus.CNT), 0);
    chk("b2b_no_stall", 32'(irdy_low), 0);
    beat(8'h00, 1'b0, 1'b0, 1'b1);

    // Backpressure: result 0x08 held while second fold (-> 0xFF) stalls at CNT=7
    for (int i = 0; i < 8; i++) beat(seq[i], 1'b1, 1'b0, 1'b0);
    chk("bp_first_o", 32'(bus.O), 32'h08);
    for (int i = 0; i < 7; i++) beat(hi[i], 1'b1, 1'b0, 1'b0);
    chk("bp_cnt7", 32'(bus.CNT), 7);
    drive(hi[7], 1'b1, 1'b0, 1'b0);
    chk("bp_iready_low", 32'(bus.I_ready), 0);
    step();
    chk("bp_cnt_held", 32'(bus.CNT), 7);
    chk("bp_o_held", 32'(bus.O), 32'h08);
    chk("bp_ovalid_held", 32'(bus.O_valid), 1);
    beat(8'h00, 1'b0, 1'b0, 1'b1);
    chk("bp_consumed", 32'(bus.O_valid), 0);
    drive(hi[7], 1'b1, 1'b0, 1'b0);
    chk("bp_iready_back", 32'(bus.I_ready), 1);
    step();
    chk("bp_second_o", 32'(bus.O), 32'hFF);
    chk("bp_second_valid", 32'(bus.O_valid), 1);
    chk("bp_second_cnt", 32'(bus.CNT), 0);
`ifdef XOR_FOLD_STREAM_PARITY_EN
    chk("bp_parity", 32'(bus.O_parity), 0);
`endif

    // Flush: 3 x 0xAA discarded; pending 0xFF untouched by the flush
    for (int i = 0; i < 3; i++) beat(8'hAA, 1'b1, 1'b0, 1'b0);
    chk("fl_cnt3", 32'(bus.CNT), 3);
    drive(8'hAA, 1'b1, 1'b1, 1'b0);
    chk("fl_iready", 32'(bus.I_ready), 0);
    step();
    chk("fl_cnt0", 32'(bus.CNT), 0);
    chk("fl_o_kept", 32'(bus.O), 32'hFF);
    chk("fl_ovalid_kept", 32'(bus.O_valid), 1);
    for (int i = 0; i < 8; i++) beat(seq[i], 1'b1, 1'b0, 1'b1);
    chk("fl_o", 32'(bus.O), 32'h08);
    chk("fl_ovalid", 32'(bus.O_valid), 1);
    chk("fl_cnt_end", 32'(bus.CNT), 0);

    // Reset mid-fold with a pending result
    for (int i = 0; i < 5; i++) beat(seq[i], 1'b1, 1'b0, 1'b0);
    chk("rm_cnt5", 32'(bus.CNT), 5);
    chk("rm_pending", 32'(bus.O_valid), 1);
    rstn = 1'b0;
    #1;
    chk("rm_cnt0", 32'(bus.CNT), 0);
    chk("rm_ovalid0", 32'(bus.O_valid), 0);
    chk("rm_o0", 32'(bus.O), 0);
    #1 rstn = 1'b1;
    beat(rv[0], 1'b1, 1'b0, 1'b1);
    chk("rm_first_beat", 32'(bus.CNT), 1);
    for (int i = 1; i < 8; i++) beat(rv[i], 1'b1, 1'b0, 1'b1);
    chk("rm_o", 32'(bus.O), 32'h7C);
    chk("rm_ovalid", 32'(bus.O_valid), 1);
`ifdef XOR_FOLD_STREAM_PARITY_EN
    chk("rm_parity", 32'(bus.O_parity), 1);
`endif
    beat(8'h00, 1'b0, 1'b0, 1'b1);

    // Bubbles: I_valid toggles, CNT holds during gaps
    for (int i = 0; i < 7; i++) begin
      beat(seq[i], 1'b1, 1'b0, 1'b1);
      beat(8'hFF, 1'b0, 1'b0, 1'b1);
      chk($sformatf("bub_cnt%0d", i + 1), 32'(bus.CNT), 32'(i + 1));
    end
    chk("bub_no_early", 32'(bus.O_valid), 0);
    beat(seq[7], 1'b1, 1'b0, 1'b1);
    chk("bub_o", 32'(bus.O), 32'h08);
    chk("bub_ovalid", 32'(bus.O_valid), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
